// File: rtl/aircon_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package    : aircon_pkg                                                |
// | Purpose    : Shared state encoding and default thresholds for the      |
// |              air-conditioning hysteresis controller (5-bit sensor).    |
// | Ports      : none (package)                                            |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
package aircon_pkg;

  // Plant state as seen on the state output. 2'b11 is never produced.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAT = 2'b01,
    ST_COOL = 2'b10
  } state_t;

  // Default thresholds for the 5-bit sensor.
  localparam int C_DEF_TEMP_W    = 5;
  localparam int C_DEF_HEAT_ON   = 18;
  localparam int C_DEF_HEAT_OFF  = 20;
  localparam int C_DEF_COOL_ON   = 22;
  localparam int C_DEF_COOL_OFF  = 20;
  localparam int C_DEF_MIN_DWELL = 4;

endpackage
`default_nettype wire

// File: rtl/aircon_hyst_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface  : aircon_hyst_ctrl_if                                       |
// | Purpose    : Sensor-side inputs and plant-drive outputs of the         |
// |              air-conditioning controller.                              |
// | Signals    : temperature, temp_valid, sensor_fault (sensor -> ctrl)    |
// |              heating, cooling, state, dwell_done   (ctrl -> plant)     |
// | Modports   : master = sensor/plant side, slave = controller            |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
interface aircon_hyst_ctrl_if #(
  parameter int TEMP_W = 5
);
  logic [TEMP_W-1:0] temperature;
  logic              temp_valid;
  logic              sensor_fault;
  logic              heating;
  logic              cooling;
  logic [1:0]        state;
  logic              dwell_done;

  modport master (
    output temperature, temp_valid, sensor_fault,
    input  heating, cooling, state, dwell_done
  );

  modport slave (
    input  temperature, temp_valid, sensor_fault,
    output heating, cooling, state, dwell_done
  );
endinterface
`default_nettype wire

// File: rtl/dwell_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : dwell_counter                                             |
// | Purpose    : Saturating up-counter with registered done flag; counts   |
// |              every clock from a clear up to MAX and holds there.       |
// | Ports      : clk   - clock, rising edge                                |
// |              rst_n - synchronous active-low reset                      |
// |              clear - restart counting from 0 at this edge              |
// |              done  - counter equals MAX (registered)                   |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module dwell_counter #(
  parameter int MAX = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clear,
  output logic      done
);

  localparam int                 c_cnt_w = $clog2(MAX + 1);
  localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_count;
  logic               r_done;

  // done is updated together with the count so it always reflects
  // the count value that is currently held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (r_count != c_max) begin
      r_count <= r_count + c_one;
      r_done  <= ((r_count + c_one) == c_max);
    end
  end

  assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/aircon_hyst_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : aircon_hyst_ctrl                                          |
// | Purpose    : IDLE/HEATING/COOLING controller with separate on/off      |
// |              thresholds (hysteresis) and a minimum dwell per state.    |
// | Ports      : clk   - clock, rising edge                                |
// |              rst_n - synchronous active-low reset                      |
// |              bus   - aircon_hyst_ctrl_if.slave:                        |
// |                      temperature/temp_valid/sensor_fault in,           |
// |                      heating/cooling/state/dwell_done out (registered) |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module aircon_hyst_ctrl
  import aircon_pkg::*;
#(
  parameter int TEMP_W    = C_DEF_TEMP_W,
  parameter int HEAT_ON   = C_DEF_HEAT_ON,
  parameter int HEAT_OFF  = C_DEF_HEAT_OFF,
  parameter int COOL_ON   = C_DEF_COOL_ON,
  parameter int COOL_OFF  = C_DEF_COOL_OFF,
  parameter int MIN_DWELL = C_DEF_MIN_DWELL
) (
  input wire logic          clk,
  input wire logic          rst_n,
  aircon_hyst_ctrl_if.slave bus
);

  generate
    if (!((HEAT_ON < HEAT_OFF) && (HEAT_OFF <= COOL_OFF) &&
          (COOL_OFF < COOL_ON) && (COOL_ON <= (2**TEMP_W) - 1) &&
          (MIN_DWELL >= 1) && (MIN_DWELL <= 255))) begin : g_bad_params
      $fatal(1, "aircon_hyst_ctrl: illegal threshold or dwell parameters");
    end
  endgenerate

  // The ordering check above guarantees every threshold fits in TEMP_W.
  localparam logic [TEMP_W-1:0] c_heat_on  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] c_heat_off = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] c_cool_on  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] c_cool_off = TEMP_W'(COOL_OFF);

  state_t r_state;
  state_t w_next;
  logic   r_heating;
  logic   r_cooling;
  logic   w_dwell_done;
  logic   w_clear;

  // Next-state decision. A fault forces IDLE regardless of dwell/valid;
  // otherwise a move needs a valid sample and a completed dwell.
  always_comb begin
    w_next = r_state;
    if (bus.sensor_fault) begin
      w_next = ST_IDLE;
    end else if (bus.temp_valid && w_dwell_done) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.temperature <= c_heat_on) begin
            w_next = ST_HEAT;
          end else if (bus.temperature >= c_cool_on) begin
            w_next = ST_COOL;
          end
        end
        ST_HEAT: if (bus.temperature >= c_heat_off) w_next = ST_IDLE;
        ST_COOL: if (bus.temperature <= c_cool_off) w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Dwell restarts only on an actual state change, so a persistent fault
  // while already IDLE lets the dwell run out.
  assign w_clear = (w_next != r_state);

  dwell_counter #(
    .MAX (MIN_DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .done  (w_dwell_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_heating <= 1'b0;
      r_cooling <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_heating <= (w_next == ST_HEAT);
      r_cooling <= (w_next == ST_COOL);
    end
  end

  assign bus.state      = r_state;
  assign bus.heating    = r_heating;
  assign bus.cooling    = r_cooling;
  assign bus.dwell_done = w_dwell_done;

endmodule
`default_nettype wire

// File: tb/tb_aircon_hyst_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : tb_aircon_hyst_ctrl                                       |
// | Purpose    : Scoreboard bench for aircon_hyst_ctrl: directed scenarios |
// |              followed by random sensor traffic, compared against a     |
// |              behavioural model of the thermostat rules.                |
// | Ports      : none                                                      |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module tb_aircon_hyst_ctrl;

  localparam int TW   = 5;
  localparam int H_ON = 18;
  localparam int H_OF = 20;
  localparam int C_ON = 22;
  localparam int C_OF = 20;
  localparam int DW   = 4;

  typedef struct packed {
    logic [1:0] st;
    logic       heat;
    logic       cool;
    logic       done;
  } exp_t;

  logic clk;
  logic rst_n;

  aircon_hyst_ctrl_if #(.TEMP_W(TW)) bus ();

  aircon_hyst_ctrl #(
    .TEMP_W    (TW),
    .HEAT_ON   (H_ON),
    .HEAT_OFF  (H_OF),
    .COOL_ON   (C_ON),
    .COOL_OFF  (C_OF),
    .MIN_DWELL (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode 0 = off, 1 = heat, 2 = cool; time_in_mode counts
  // clocks since the last mode change, capped at the dwell length.
  int mode = 0;
  int time_in_mode = 0;

  task automatic model_edge(input bit rn, input int t, input bit v, input bit f);
    int  nm;
    bit  may_move;
    exp_t e;
    if (!rn) begin
      mode = 0;
      time_in_mode = 0;
    end else begin
      nm = mode;
      may_move = v && (time_in_mode >= DW);
      if (f) nm = 0;
      else if (may_move) begin
        if (mode == 0) nm = (t <= H_ON) ? 1 : ((t >= C_ON) ? 2 : 0);
        else if (mode == 1) nm = (t >= H_OF) ? 0 : 1;
        else nm = (t <= C_OF) ? 0 : 2;
      end
      if (nm != mode) time_in_mode = 0;
      else if (time_in_mode < DW) time_in_mode++;
      mode = nm;
    end
    e.st   = 2'(mode);
    e.heat = (mode == 1);
    e.cool = (mode == 2);
    e.done = (time_in_mode == DW);
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: inputs change on the falling edge, the model
  // records the expected result of the following rising edge.
  task automatic drive(input bit rn, input int t, input bit v, input bit f);
    @(negedge clk);
    rst_n            = rn;
    bus.temperature  = TW'(t);
    bus.temp_valid   = v;
    bus.sensor_fault = f;
    @(posedge clk);
    model_edge(rn, t, v, f);
  endtask

  task automatic repeat_drive(input int n, input bit rn, input int t, input bit v, input bit f);
    for (int i = 0; i < n; i++) drive(rn, t, v, f);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are presented every clock; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state",      int'(bus.state),      int'(e.st));
      chk("heating",    int'(bus.heating),    int'(e.heat));
      chk("cooling",    int'(bus.cooling),    int'(e.cool));
      chk("dwell_done", int'(bus.dwell_done), int'(e.done));
      chk("exclusive",  int'(bus.heating & bus.cooling), 0);
    end
  end

  initial begin
    rst_n            = 1'b0;
    bus.temperature  = '0;
    bus.temp_valid   = 1'b0;
    bus.sensor_fault = 1'b0;

    // Reset with a cold valid sample, then heating after the dwell.
    repeat_drive(2, 0, 10, 1, 0);
    repeat_drive(7, 1, 10, 1, 0);
    // Heating-side hysteresis.
    repeat_drive(6, 1, 19, 1, 0);
    repeat_drive(2, 1, 20, 1, 0);
    // Cool entry, then immediate cool-off request held by dwell.
    repeat_drive(6, 1, 21, 1, 0);
    drive(1, 22, 1, 0);
    repeat_drive(7, 1, 20, 1, 0);
    // No direct heat->cool swap.
    repeat_drive(7, 1, 15, 1, 0);
    repeat_drive(14, 1, 30, 1, 0);
    // Fault in COOLING, then invalid cold samples.
    drive(1, 25, 1, 1);
    repeat_drive(10, 1, 5, 0, 0);
    // Range extremes and reset mid-COOLING.
    repeat_drive(8, 1, 0, 1, 0);
    repeat_drive(14, 1, 31, 1, 0);
    drive(0, 31, 1, 0);
    repeat_drive(3, 1, 31, 1, 0);

    // Random traffic, weighted toward the threshold region.
    for (int i = 0; i < 3000; i++) begin
      int  t;
      bit  v, f, rn;
      t  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                       : int'($urandom_range(16, 24));
      v  = ($urandom_range(0, 9) < 8);
      f  = ($urandom_range(0, 49) == 0);
      rn = ($urandom_range(0, 199) != 0);
      drive(rn, t, v, f);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aircon_hyst_ctrl.md
Name: aircon_hyst_ctrl

Overview:
- Registered air-conditioning controller driven by a sampled temperature word.
- Three-state machine (IDLE/HEATING/COOLING) with separate on/off thresholds for hysteresis.
- Minimum-dwell counter stops the plant from short-cycling.
- Sits between the temperature sensor interface and the heater/cooler drive outputs. Replaces the earlier purely combinational threshold compare.

Parameters:
- TEMP_W, 5: width of the unsigned temperature sample.
- HEAT_ON, 18: IDLE->HEATING when temperature <= HEAT_ON.
- HEAT_OFF, 20: HEATING->IDLE permitted when temperature >= HEAT_OFF.
- COOL_ON, 22: IDLE->COOLING when temperature >= COOL_ON.
- COOL_OFF, 20: COOLING->IDLE permitted when temperature <= COOL_OFF.
- MIN_DWELL, 4: minimum clocks spent in any state before it may be left; legal range 1..255.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- temperature, input, TEMP_W: unsigned temperature sample.
- temp_valid, input, 1: temperature is valid this cycle. Transitions are evaluated only when high.
- sensor_fault, input, 1: sensor fault. Forces IDLE immediately.
- heating, output, 1: heater drive, registered.
- cooling, output, 1: cooler drive, registered.
- state, output, 2: current state: 00 IDLE, 01 HEATING, 10 COOLING. 11 is never driven.
- dwell_done, output, 1: dwell counter has reached MIN_DWELL, registered.

Behaviour:
- Single clock domain on clk. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: state=IDLE, heating=0, cooling=0, dwell count=0, dwell_done=0. Reset wins over every other input, including mid-dwell or mid-heating.
- Elaboration check, violation is a fatal error: HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON, and COOL_ON <= 2^TEMP_W-1.
- Dwell counter:
  - Width clog2(MIN_DWELL+1).
  - Cleared to 0 on every state change.
  - Otherwise increments every clock, independent of temp_valid, and saturates at MIN_DWELL.
  - dwell_done = (count == MIN_DWELL), registered with the counter.
- Transitions are evaluated at rising edge N. They require temp_valid=1, sensor_fault=0 and dwell_done=1, all sampled at edge N.
  - IDLE: if temperature <= HEAT_ON -> HEATING; else if temperature >= COOL_ON -> COOLING; else stay.
  - HEATING: if temperature >= HEAT_OFF -> IDLE; else stay.
  - COOLING: if temperature <= COOL_OFF -> IDLE; else stay.
  - No direct HEATING<->COOLING transition. The path always passes through IDLE and serves a full dwell there.
- Latency: a qualifying sample at edge N updates state, heating and cooling at edge N, so they are visible in cycle N+1. No combinational path from inputs to outputs.
- Output decode, registered: heating=1 iff next state is HEATING; cooling=1 iff next state is COOLING. heating and cooling are never both 1.
- sensor_fault=1 at an edge:
  - Next state IDLE, outputs 0, counter cleared. This ignores temp_valid and dwell.
  - While fault persists the block holds IDLE with counter counting. Normal operation resumes when fault drops, subject to dwell.
- temp_valid=0: state held, counter still advances.
- Temperature exactly on a threshold is a match, since all compares are inclusive.
- Out-of-range values cannot occur, because the input is unsigned and the full TEMP_W range is legal.

Decomposition:
- Shared package aircon_pkg:
  - state encoding constants ST_IDLE=2'b00, ST_HEAT=2'b01, ST_COOL=2'b10;
  - default threshold localparams for the 5-bit sensor.
- One natural sub-module: dwell_counter. Ports: clk, rst_n, clear, done. Parameter MAX. It is a saturating counter, reused later for fan run-on.
- FSM, compares and output registers stay in aircon_hyst_ctrl.

Test Plan:
- Reset check: rst_n=0 for 2 cycles with temperature=10 and valid -> state=00, heating=0, cooling=0. After release, HEATING is entered only on the edge where dwell_done=1, i.e. 4 cycles after reset release.
- Hysteresis, heating side: from HEATING, apply temperature 19 -> stays HEATING. Apply 20 -> IDLE next cycle, heating=0.
- Cool and dwell: from IDLE with dwell_done, apply 22 -> COOLING. Immediately apply 20 -> state held COOLING until 4 cycles after entry, then IDLE.
- No direct swap: in HEATING, apply temperature 30 -> IDLE first, cooling=0 for MIN_DWELL cycles, then COOLING. heating and cooling never both 1.
- Fault and valid gating: in COOLING, assert sensor_fault for 1 cycle -> IDLE and cooling=0 the next cycle. With temp_valid=0 and temperature=5 held for 10 cycles -> state stays IDLE.
- Boundaries: with TEMP_W=5, temperature=0 -> HEATING; temperature=31 -> COOLING after the dwell. Reset asserted mid-COOLING -> IDLE and outputs 0 at that edge.
